// File: rtl/regwrite_decoder_stage.sv
// regwrite_decoder_stage: staged one-hot register-file write enable with zero-register masking and read-hit compare
module regwrite_decoder_stage #(
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   RegWrite,
   input  logic [ADDR_W-1:0]      WriteRegister,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [ADDR_W-1:0]      ReadRegA,
   input  logic [ADDR_W-1:0]      ReadRegB,
   output logic [(2**ADDR_W)-1:0] wr_en,
   output logic                   wr_valid,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic                   hit_a,
   output logic                   hit_b
);
   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic ZERO_EN = (ZERO_REG >= 0) && (ZERO_REG < NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   logic              v_q, v_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   always_comb begin
      v_d    = flush ? 1'b0 : stall ? v_q : RegWrite;
      addr_d = (flush || stall) ? addr_q : WriteRegister;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q    <= 1'b0;
         addr_q <= '0;
      end else begin
         v_q    <= v_d;
         addr_q <= addr_d;
      end
   end
   always_comb begin
      wr_valid = v_q && !(ZERO_EN && addr_q == ZERO_A);
      wr_en    = NUM_REGS'(wr_valid) << addr_q;
      wr_addr  = addr_q;
      hit_a    = wr_valid && (ReadRegA == addr_q);
      hit_b    = wr_valid && (ReadRegB == addr_q);
   end
endmodule

// File: tb/tb_regwrite_decoder_stage.sv
// tb_regwrite_decoder_stage: directed and random checks of the default and a 3-bit unmasked instance against a reference model
module tb_regwrite_decoder_stage;
   logic clk = 0, reset = 1, RegWrite = 0, stall = 0, flush = 0;
   logic [4:0] WriteRegister = 0, ReadRegA = 0, ReadRegB = 0;
   logic [31:0] wr_en;
   logic wr_valid, hit_a, hit_b;
   logic [4:0] wr_addr;
   logic [7:0] wr_en3;
   logic wr_valid3, hit_a3, hit_b3;
   logic [2:0] wr_addr3;
   int checks = 0, failures = 0;
   logic m_v = 0, m3_v = 0;
   logic [4:0] m_a = 0;
   logic [2:0] m3_a = 0;

   always #5 clk = ~clk;

   regwrite_decoder_stage dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .stall(stall), .flush(flush), .ReadRegA(ReadRegA), .ReadRegB(ReadRegB),
      .wr_en(wr_en), .wr_valid(wr_valid), .wr_addr(wr_addr), .hit_a(hit_a), .hit_b(hit_b)
   );

   regwrite_decoder_stage #(.ADDR_W(3), .ZERO_REG(8)) dut3 (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister[2:0]),
      .stall(stall), .flush(flush), .ReadRegA(ReadRegA[2:0]), .ReadRegB(ReadRegB[2:0]),
      .wr_en(wr_en3), .wr_valid(wr_valid3), .wr_addr(wr_addr3), .hit_a(hit_a3), .hit_b(hit_b3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_model();
      logic ok;
      ok = m_v && (m_a != 5'd31);
      chk("wr_valid", {31'b0, wr_valid}, {31'b0, ok});
      chk("wr_en", wr_en, ok ? (32'b1 << m_a) : 32'b0);
      chk("wr_addr", {27'b0, wr_addr}, {27'b0, m_a});
      chk("hit_a", {31'b0, hit_a}, {31'b0, ok && ReadRegA == m_a});
      chk("hit_b", {31'b0, hit_b}, {31'b0, ok && ReadRegB == m_a});
      chk("wr_en3", {24'b0, wr_en3}, m3_v ? (32'b1 << m3_a) : 32'b0);
      chk("wr_valid3", {31'b0, wr_valid3}, {31'b0, m3_v});
      chk("wr_addr3", {29'b0, wr_addr3}, {29'b0, m3_a});
      chk("hit_a3", {31'b0, hit_a3}, {31'b0, m3_v && ReadRegA[2:0] == m3_a});
      chk("hit_b3", {31'b0, hit_b3}, {31'b0, m3_v && ReadRegB[2:0] == m3_a});
   endtask

   task automatic step(input logic rw, input logic [4:0] wa, input logic st, input logic fl,
                       input logic rs, input logic [4:0] ra, input logic [4:0] rb);
      RegWrite = rw; WriteRegister = wa; stall = st; flush = fl; reset = rs;
      ReadRegA = ra; ReadRegB = rb;
      @(posedge clk);
      if (rs) begin
         m_v = 0; m_a = 0; m3_v = 0; m3_a = 0;
      end else if (fl) begin
         m_v = 0; m3_v = 0;
      end else if (!st) begin
         m_v = rw; m_a = wa; m3_v = rw; m3_a = wa[2:0];
      end
      #1;
      check_model();
   endtask

   initial begin
      step(1, 7, 0, 0, 1, 0, 0);
      chk("rst_en", wr_en, 32'h0);
      step(1, 7, 0, 0, 1, 7, 7);
      chk("rst_hit", {31'b0, hit_a}, 32'h0);
      step(1, 7, 0, 0, 0, 0, 0);
      chk("rel_en", wr_en, 32'h80);
      for (int a = 0; a < 32; a++) step(1, 5'(a), 0, 0, 0, 5'(a), 0);
      chk("zero_valid", {31'b0, wr_valid}, 32'h0);
      chk("zero3_en", {24'b0, wr_en3}, 32'h80);
      step(0, 5, 0, 0, 0, 0, 0);
      chk("nowr_addr", {27'b0, wr_addr}, 32'd5);
      step(1, 3, 0, 0, 0, 0, 0);
      step(1, 9, 1, 0, 0, 0, 0);
      chk("stall1", wr_en, 32'h8);
      step(1, 9, 1, 0, 0, 0, 0);
      chk("stall2", wr_en, 32'h8);
      step(1, 9, 1, 1, 0, 0, 0);
      chk("flush_wins", wr_en, 32'h0);
      step(1, 12, 0, 0, 0, 12, 4);
      chk("hit_a12", {31'b0, hit_a}, 32'h1);
      chk("hit_b4", {31'b0, hit_b}, 32'h0);
      step(1, 31, 0, 0, 0, 31, 31);
      chk("hit_zero", {31'b0, hit_a}, 32'h0);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
              5'($urandom), 5'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regwrite_decoder_stage.md
# regwrite_decoder_stage

Parametrised, pipelined write-enable decoder for the register file's write-back port. It captures a write request (`RegWrite`, destination address) into a one-entry stage register and drives a one-hot per-register write-enable vector from that register one cycle later. The zero register is masked, and the stage supports stall and flush from pipeline control. It also reports whether either register-read address matches the staged write, which feeds the forwarding unit. It replaces the fixed-width combinational write decode in front of the register file.

## Interface
Parameters:
- `ADDR_W`, default 5: destination address width; `NUM_REGS = 2**ADDR_W`.
- `ZERO_REG`, default 31: hardwired-zero register index; writes to it are never enabled.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RegWrite`  in  1  write request from the upstream stage.
- `WriteRegister`  in  ADDR_W  destination register of the request.
- `stall`  in  1  hold the stage register contents.
- `flush`  in  1  invalidate the stage register.
- `ReadRegA`  in  ADDR_W  read-port A address, used for hit compare.
- `ReadRegB`  in  ADDR_W  read-port B address, used for hit compare.
- `wr_en`  out  NUM_REGS  one-hot write enables to the register file, or all zero.
- `wr_valid`  out  1  staged request is valid and targets a non-zero register.
- `wr_addr`  out  ADDR_W  staged destination address.
- `hit_a`  out  1  staged write matches `ReadRegA`.
- `hit_b`  out  1  staged write matches `ReadRegB`.

## Operation
- Stage register fields: `v_q` (1 bit) and `addr_q` (ADDR_W bits).
- Update priority on each rising edge, highest first:
  1. `reset`: `v_q` = 0, `addr_q` = 0.
  2. `flush`: `v_q` = 0, `addr_q` holds.
  3. `stall`: `v_q` and `addr_q` hold.
  4. Otherwise: `v_q` = `RegWrite`, `addr_q` = `WriteRegister`.
- `wr_valid` = `v_q` and (`addr_q` != `ZERO_REG`).
- `wr_en[i]` = `wr_valid` and (`addr_q` == i), for i in 0..NUM_REGS-1. At most one bit is set.
- `wr_addr` = `addr_q`, driven even when `wr_valid` = 0.
- `hit_a` = `wr_valid` and (`ReadRegA` == `addr_q`). `hit_b` is the same compare against `ReadRegB`. A read of `ZERO_REG` therefore never hits.
- Two-state behaviour: EMPTY (`v_q` = 0) and HELD (`v_q` = 1).
  - EMPTY to HELD: unstalled, unflushed edge with `RegWrite` = 1.
  - HELD to EMPTY: flush, reset, or an unstalled edge with `RegWrite` = 0.
  - HELD to HELD with a new address: unstalled edge with `RegWrite` = 1.
  - Stall holds the current state.
- A write to `ZERO_REG` is captured (`v_q` = 1) but produces `wr_en` = 0, `wr_valid` = 0 and no hits.
- `ZERO_REG` outside 0..NUM_REGS-1 disables masking; every address is then writable.

## Timing
- Reset values: `wr_en` = 0, `wr_valid` = 0, `wr_addr` = 0, `hit_a` = 0, `hit_b` = 0.
- Latency: a request present at edge N drives `wr_en` from just after edge N until edge N+1. Exactly one cycle.
- `hit_a` and `hit_b` are combinational from `ReadRegA`/`ReadRegB` and the registered state. They are valid in the same cycle as `wr_en`.
- Back-to-back requests are accepted every cycle; each `wr_en` pulse lasts one cycle per request.
- Stall for K cycles repeats the same `wr_en` for K+1 cycles. The register file is idempotent, so this is allowed.
- Flush takes effect at the next edge; the current cycle's `wr_en` is unaffected.
- Reset asserted mid-sequence clears the stage at that edge; the following cycle has `wr_en` = 0.
- No combinational path from `RegWrite` or `WriteRegister` to any output.

## Test plan
- Reset: hold `reset` = 1 for 2 cycles with `RegWrite` = 1, `WriteRegister` = 7 -> all outputs 0 during reset and for the first cycle after release; `wr_en` = 1<<7 in the second cycle after release.
- Decode sweep (ADDR_W = 5): `RegWrite` = 1 with addresses 0..30 on consecutive cycles -> `wr_en` = 1<<a one cycle later for each a. Address 31 -> `wr_en` = 0, `wr_valid` = 0.
- `RegWrite` = 0 with `WriteRegister` = 5 -> next cycle `wr_en` = 0, `wr_addr` = 5.
- Stall/flush: capture address 3, stall 2 cycles while `WriteRegister` = 9 -> `wr_en` = 1<<3 for 3 cycles. Then assert `stall` = 1 and `flush` = 1 together -> next cycle `wr_en` = 0 (flush wins).
- Hits: stage address 12 with `ReadRegA` = 12, `ReadRegB` = 4 -> `hit_a` = 1, `hit_b` = 0. Stage address 31 with `ReadRegA` = 31 -> `hit_a` = 0.
- Parametrisation: ADDR_W = 3, ZERO_REG = 8 -> address 7 gives `wr_en` = 8'h80, and all 8 addresses are writable.
